// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side initiator for a 2^ADDR_W x DATA_W data memory.
// Accepts one LOAD / STORE / SWAP / FILL request at a time, sequences the
// memory strobes, and returns a result over a valid/ready response channel.
// All memory-facing outputs are registered so they change only on clk and
// drop to their reset values immediately on an asynchronous reset.
// Optional feature: define MEM_ACCESS_STATS_EN to add the stat_count output
// (saturating count of completed response handshakes).
module mem_access_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int FILL_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]       stat_count
`endif
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    // Counter value of the final FILL write; FILL_LEN-1 always fits in ADDR_W bits.
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FILL_LEN - 1);

    // A FILL longer than the memory, or empty, is a build-time mistake.
    if (FILL_LEN < 1 || FILL_LEN > (2 ** ADDR_W)) begin : g_cfg_error
        $error("mem_access_ctrl: FILL_LEN=%0d outside legal range 1..%0d",
               FILL_LEN, 2 ** ADDR_W);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_RESP
    } state_t;

    state_t            state_reg,     state_next;
    logic [1:0]        op_reg,        op_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [DATA_W-1:0] wdata_reg,     wdata_next;
    logic [ADDR_W-1:0] count_reg,     count_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              mem_read_reg,  mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [DATA_W-1:0] rsp_data_reg,  rsp_data_next;

    // State and registered-output update; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_LOAD;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            count_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            count_reg     <= count_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    // Next-state logic; strobes are computed for the state being entered so
    // they are already registered when that state begins.
    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        count_next     = count_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        rsp_data_next  = rsp_data_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    op_next       = req_op;
                    addr_next     = req_addr;
                    wdata_next    = req_wdata;
                    count_next    = '0;
                    mem_addr_next = req_addr;
                    unique case (req_op)
                        OP_LOAD, OP_SWAP: begin
                            state_next    = S_READ;
                            mem_read_next = 1'b1;
                        end
                        OP_STORE: begin
                            state_next     = S_WRITE;
                            mem_write_next = 1'b1;
                            mem_wdata_next = req_wdata;
                        end
                        default: begin
                            state_next     = S_FILL;
                            mem_write_next = 1'b1;
                            mem_wdata_next = req_wdata;
                        end
                    endcase
                end
            end

            S_READ: begin
                // Memory read data is combinational; capture it at the end of READ.
                rsp_data_next = mem_rdata;
                if (op_reg == OP_SWAP) begin
                    state_next     = S_WRITE;
                    mem_write_next = 1'b1;
                    mem_wdata_next = wdata_reg;
                end else begin
                    state_next = S_RESP;
                end
            end

            S_WRITE: begin
                // SWAP keeps the old data it read; STORE reports what it wrote.
                if (op_reg == OP_STORE) begin
                    rsp_data_next = wdata_reg;
                end
                state_next = S_RESP;
            end

            S_FILL: begin
                if (count_reg == FILL_LAST) begin
                    state_next    = S_RESP;
                    rsp_data_next = wdata_reg;
                end else begin
                    count_next     = count_reg + ADDR_W'(1);
                    // ADDR_W-bit sum wraps naturally past the top of memory.
                    mem_addr_next  = addr_reg + count_next;
                    mem_write_next = 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_data  = rsp_data_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_count_reg;

    // Count completed response handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_reg <= '0;
        end else if (state_reg == S_RESP && rsp_ready && stat_count_reg != 16'hFFFF) begin
            stat_count_reg <= stat_count_reg + 16'd1;
        end
    end

    assign stat_count = stat_count_reg;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a 16x8 behavioural memory
// (combinational read, write on rising clk). Built with FILL_LEN=4.
module tb_mem_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int FL = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0]   stat_count;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural memory and strobe monitor
    logic [DW-1:0] ram [16];
    logic          load_init;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            rd_cyc = 0;
    int            both_cnt = 0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr_q [$];
    int            wr_cyc_q [$];

    mem_access_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .FILL_LEN(FL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .busy     (busy)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (load_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= DW'(i);
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_read) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = mem_addr;
            rd_cyc  = cyc;
        end
        if (mem_write) begin
            wr_addr_q.push_back(mem_addr);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_read && mem_write) both_cnt = both_cnt + 1;
    end

    // Present one request at a negedge; returns at the first negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count cycles (from the current one, numbered 1) until rsp_valid; bounded.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_load(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        issue(OP_LOAD, a, '0);
        wait_resp(lat);
        d = rsp_data;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready actual=%b required=1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes actual=%b required=00", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus actual=%h/%h required=0/00", mem_addr, mem_wdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp actual=%b/%h required=0/00", rsp_valid, rsp_data); end
`ifdef MEM_ACCESS_STATS_EN
        checks++; if (stat_count !== 16'd0) begin errors++; $display("FAIL reset_stat actual=%0d required=0", stat_count); end
`endif
        @(negedge clk);
        load_init = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        $display("reset: checked reset state");
    endtask

    task automatic test_load;
        int r0;
        int w0;
        int lat;
        r0 = rd_cnt;
        w0 = wr_addr_q.size();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL load_req_ready actual=%b required=1", req_ready); end
        issue(OP_LOAD, 4'd5, 8'h00);
        checks++; if (mem_read !== 1'b1 || mem_addr !== 4'd5) begin errors++; $display("FAIL load_read_cycle actual=%b@%0d required=1@5", mem_read, mem_addr); end
        wait_resp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency actual=%0d required=2", lat); end
        checks++; if (rsp_data !== 8'h05) begin errors++; $display("FAIL load_data actual=%h required=05", rsp_data); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL load_read_drop actual=%b required=0", mem_read); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL load_idle actual=%b/%b required=0/1", busy, req_ready); end
        checks++; if (rd_cnt - r0 != 1 || rd_addr !== 4'd5) begin errors++; $display("FAIL load_read_count actual=%0d@%0d required=1@5", rd_cnt - r0, rd_addr); end
        checks++; if (wr_addr_q.size() != w0) begin errors++; $display("FAIL load_no_write actual=%0d required=0", wr_addr_q.size() - w0); end
        $display("load: addr 5 -> %h latency %0d", rsp_data, lat);
    endtask

    task automatic test_store;
        int w0;
        int lat;
        logic [DW-1:0] d;
        w0 = wr_addr_q.size();
        issue(OP_STORE, 4'd3, 8'hA7);
        wait_resp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL store_latency actual=%0d required=2", lat); end
        checks++; if (rsp_data !== 8'hA7) begin errors++; $display("FAIL store_rsp actual=%h required=a7", rsp_data); end
        @(negedge clk);
        checks++; if (wr_addr_q.size() - w0 != 1 || wr_addr_q[w0] !== 4'd3) begin errors++; $display("FAIL store_write actual=%0d writes@%0d required=1@3", wr_addr_q.size() - w0, wr_addr_q[w0]); end
        checks++; if (mem_addr !== 4'd3 || mem_wdata !== 8'hA7) begin errors++; $display("FAIL store_hold_bus actual=%0d/%h required=3/a7", mem_addr, mem_wdata); end
        do_load(4'd3, d, lat);
        checks++; if (d !== 8'hA7) begin errors++; $display("FAIL store_readback actual=%h required=a7", d); end
        $display("store: addr 3 <- a7, readback %h", d);
    endtask

    task automatic test_swap;
        int w0;
        int r0;
        int lat;
        logic [DW-1:0] d;
        w0 = wr_addr_q.size();
        r0 = rd_cnt;
        issue(OP_SWAP, 4'd9, 8'h3C);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 4'd9) begin errors++; $display("FAIL swap_read_cycle actual=%b%b@%0d required=10@9", mem_read, mem_write, mem_addr); end
        wait_resp(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL swap_latency actual=%0d required=3", lat); end
        checks++; if (rsp_data !== 8'h09) begin errors++; $display("FAIL swap_rsp actual=%h required=09", rsp_data); end
        @(negedge clk);
        checks++; if (rd_cnt - r0 != 1 || wr_addr_q.size() - w0 != 1) begin errors++; $display("FAIL swap_strobes actual=%0d reads %0d writes required=1/1", rd_cnt - r0, wr_addr_q.size() - w0); end
        checks++; if (wr_cyc_q[w0] != rd_cyc + 1 || wr_addr_q[w0] !== 4'd9) begin errors++; $display("FAIL swap_order actual=wcyc %0d rcyc %0d addr %0d required=rcyc+1,9", wr_cyc_q[w0], rd_cyc, wr_addr_q[w0]); end
        do_load(4'd9, d, lat);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL swap_readback actual=%h required=3c", d); end
        $display("swap: addr 9 old %h new %h", 8'h09, d);
    endtask

    task automatic test_fill;
        int w0;
        int lat;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_a [4];
        logic [AW-1:0] chk_a [5];
        logic [DW-1:0] chk_d [5];
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        chk_a = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        chk_d = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h02};
        w0 = wr_addr_q.size();
        issue(OP_FILL, 4'd14, 8'h55);
        wait_resp(lat);
        checks++; if (lat != FL + 1) begin errors++; $display("FAIL fill_latency actual=%0d required=%0d", lat, FL + 1); end
        checks++; if (rsp_data !== 8'h55) begin errors++; $display("FAIL fill_rsp actual=%h required=55", rsp_data); end
        @(negedge clk);
        checks++; if (wr_addr_q.size() - w0 != FL) begin errors++; $display("FAIL fill_count actual=%0d required=%0d", wr_addr_q.size() - w0, FL); end
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (wr_addr_q[w0 + i] !== exp_a[i] || wr_cyc_q[w0 + i] != wr_cyc_q[w0] + i) begin
                errors++;
                $display("FAIL fill_write%0d actual=addr %0d cyc+%0d required=addr %0d cyc+%0d", i, wr_addr_q[w0 + i], wr_cyc_q[w0 + i] - wr_cyc_q[w0], exp_a[i], i);
            end
        end
        for (int i = 0; i < 5; i++) begin
            do_load(chk_a[i], d, lat);
            checks++; if (d !== chk_d[i]) begin errors++; $display("FAIL fill_readback%0d actual=%h required=%h", chk_a[i], d, chk_d[i]); end
        end
        $display("fill: 14..1 <- 55, wrapped");
    endtask

    task automatic test_backpressure;
        int r0;
        int w0;
        int lat;
        r0 = rd_cnt;
        w0 = wr_addr_q.size();
        rsp_ready = 1'b0;
        issue(OP_LOAD, 4'd7, 8'h00);
        wait_resp(lat);
        checks++; if (lat != 2 || rsp_data !== 8'h07) begin errors++; $display("FAIL bp_first actual=lat %0d data %h required=2/07", lat, rsp_data); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h07 || req_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d actual=v%b d%h rdy%b rd%b wr%b required=v1 d07 rdy0 rd0 wr0", i, rsp_valid, rsp_data, req_ready, mem_read, mem_write);
            end
        end
        checks++; if (rd_cnt - r0 != 1 || wr_addr_q.size() != w0) begin errors++; $display("FAIL bp_strobes actual=%0d/%0d required=1/0", rd_cnt - r0, wr_addr_q.size() - w0); end
        // Release the response with a new request already waiting.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_STORE;
        req_addr  = 4'd7;
        req_wdata = 8'h11;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release actual=busy%b rdy%b v%b required=0/1/0", busy, req_ready, rsp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_write !== 1'b1 || mem_addr !== 4'd7 || mem_wdata !== 8'h11) begin errors++; $display("FAIL bp_next_store actual=%b@%0d=%h required=1@7=11", mem_write, mem_addr, mem_wdata); end
        wait_resp(lat);
        checks++; if (lat != 2 || rsp_data !== 8'h11) begin errors++; $display("FAIL bp_next_rsp actual=lat %0d data %h required=2/11", lat, rsp_data); end
        @(negedge clk);
        $display("backpressure: held 5 cycles, follow-on store accepted after idle cycle");
    endtask

    task automatic test_reset_mid_fill;
        int w0;
        int lat;
        logic [DW-1:0] d;
        logic [AW-1:0] chk_a [3];
        logic [DW-1:0] chk_d [3];
        chk_a = '{4'd4, 4'd5, 4'd6};
        chk_d = '{8'hEE, 8'hEE, 8'h06};
        w0 = wr_addr_q.size();
        issue(OP_FILL, 4'd4, 8'hEE);
        @(negedge clk);
        @(negedge clk);
        checks++; if (wr_addr_q.size() - w0 != 2) begin errors++; $display("FAIL midfill_pre actual=%0d required=2", wr_addr_q.size() - w0); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL midfill_bus actual=%b%b %0d %h required=00 0 00", mem_read, mem_write, mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL midfill_ctrl actual=busy%b rdy%b v%b d%h required=0/1/0/00", busy, req_ready, rsp_valid, rsp_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (wr_addr_q.size() - w0 != 2) begin errors++; $display("FAIL midfill_writes actual=%0d required=2", wr_addr_q.size() - w0); end
`ifdef MEM_ACCESS_STATS_EN
        checks++; if (stat_count !== 16'd0) begin errors++; $display("FAIL stat_after_reset actual=%0d required=0", stat_count); end
`endif
        for (int i = 0; i < 3; i++) begin
            do_load(chk_a[i], d, lat);
            checks++; if (d !== chk_d[i]) begin errors++; $display("FAIL midfill_readback%0d actual=%h required=%h", chk_a[i], d, chk_d[i]); end
        end
`ifdef MEM_ACCESS_STATS_EN
        checks++; if (stat_count !== 16'd3) begin errors++; $display("FAIL stat_three actual=%0d required=3", stat_count); end
`endif
        $display("reset mid-fill: only addresses 4,5 modified");
    endtask

    task automatic test_exclusive;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_exclusive actual=%0d required=0", both_cnt); end
        $display("exclusive: read/write overlap cycles %0d", both_cnt);
    endtask

    initial begin
        rst_n     = 1'b1;
        load_init = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_LOAD;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #1 rst_n  = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_swap();
        test_fill();
        test_backpressure();
        test_reset_mid_fill();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
